// File: rtl/ftb_store.sv
// ftb_store: parametrised set-associative fetch target buffer storage.
// Lookups return a registered prediction one cycle after acceptance. Updates
// are latched, then read-modify-written one cycle later. An init sweep clears
// the valid bits after reset and after every flush.

package ftb_store_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JUMP = 2'd2,
    BR_RET  = 2'd3
  } branch_type_e;

  // Relation of the stored target's high part to the block pc's high part.
  typedef enum logic [1:0] {
    TAR_FIT = 2'd0,
    TAR_OVF = 2'd1,
    TAR_UDF = 2'd2
  } tar_stat_e;

endpackage

module ftb_store
  import ftb_store_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NSETS      = 64,
  parameter int NWAYS      = 4,
  parameter int TAG_W      = 16,
  parameter int TARGET_W   = 12,
  parameter int FALLTHRU_W = 5,
  parameter int CNTR_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            lkp_vld,
  output logic            lkp_rdy,
  input  logic [XLEN-1:0] lkp_pc,
  output logic            rsp_vld,
  output logic            rsp_hit,
  output logic            rsp_taken,
  output logic [XLEN-1:0] rsp_fallthru,
  output logic [XLEN-1:0] rsp_npc,
  output branch_type_e    rsp_brtype,
  input  logic            upd_vld,
  output logic            upd_rdy,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_fallthru,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  branch_type_e    upd_brtype,
  output logic            upd_drop
);

  localparam int IDXW = $clog2(NSETS);
  localparam int WAYW = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int HW   = XLEN - TARGET_W - 1;
  localparam int FHW  = XLEN - FALLTHRU_W - 1;

  localparam logic [IDXW-1:0]   IDX_ONE    = IDXW'(1'b1);
  localparam logic [IDXW-1:0]   IDX_LAST   = IDXW'(NSETS - 1);
  localparam logic [WAYW-1:0]   WAY_ONE    = WAYW'(1'b1);
  localparam logic [HW-1:0]     H_ONE      = HW'(1'b1);
  localparam logic [FHW-1:0]    F_ONE      = FHW'(1'b1);
  localparam logic [CNTR_W-1:0] CNTR_ONE   = CNTR_W'(1'b1);
  localparam logic [CNTR_W-1:0] CNTR_MAX   = {CNTR_W{1'b1}};
  localparam logic [CNTR_W-1:0] CNTR_ZERO  = {CNTR_W{1'b0}};
  localparam logic [CNTR_W-1:0] CNTR_WEAKT = CNTR_ONE << (CNTR_W - 1);
  localparam logic [CNTR_W-1:0] CNTR_WEAKN = CNTR_WEAKT - CNTR_ONE;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_UPD  = 2'd2
  } state_e;

  // Lowest set bit of a way vector; multiple tag matches resolve to the lowest way.
  function automatic logic [WAYW-1:0] low_way(input logic [NWAYS-1:0] vec);
    logic [WAYW-1:0] way;
    way = {WAYW{1'b0}};
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (vec[w]) begin
        way = WAYW'(w);
      end else begin
        way = way;
      end
    end
    return way;
  endfunction

  // Control state, valid bits and replacement pointers carry a reset.
  state_e                         state_r, next_state_s;
  logic [IDXW-1:0]                sweep_idx_r, sweep_idx_next_s;
  logic                           lkp_rdy_r, upd_rdy_r, upd_drop_r;
  logic [NSETS-1:0][NWAYS-1:0]    vld_r;
  logic [NSETS-1:0][NWAYS-1:0]    carry_r;
  logic [NSETS-1:0][WAYW-1:0]     rr_r;

  // Entry payload; only meaningful where the matching valid bit is set.
  logic [TAG_W-1:0]      tag_r  [NSETS][NWAYS];
  logic [FALLTHRU_W-1:0] ft_r   [NSETS][NWAYS];
  logic [TARGET_W-1:0]   tgt_r  [NSETS][NWAYS];
  tar_stat_e             stat_r [NSETS][NWAYS];
  branch_type_e          br_r   [NSETS][NWAYS];
  logic [CNTR_W-1:0]     cntr_r [NSETS][NWAYS];

  // Latched update request, already encoded.
  logic [IDXW-1:0]       u_idx_r;
  logic [TAG_W-1:0]      u_tag_r;
  logic [TARGET_W-1:0]   u_tgt_r;
  tar_stat_e             u_stat_r;
  logic                  u_carry_r;
  logic [FALLTHRU_W-1:0] u_ft_r;
  logic                  u_taken_r;
  branch_type_e          u_br_r;
  logic                  u_ok_r;

  // Registered response.
  logic                  rsp_vld_r, rsp_hit_r, rsp_taken_r;
  logic [XLEN-1:0]       rsp_ft_r, rsp_npc_r;
  branch_type_e          rsp_br_r;

  logic                  lkp_acc_s, upd_acc_s, init_clr_s, upd_wr_s;
  logic [IDXW-1:0]       lkp_idx_s;
  logic [TAG_W-1:0]      lkp_tag_s;
  logic [HW-1:0]         lkp_h_s, lkp_th_s;
  logic [FHW-1:0]        lkp_fh_s;
  logic [NWAYS-1:0]      lkp_match_s;
  logic                  lkp_hit_s, lkp_taken_s;
  logic [WAYW-1:0]       lkp_way_s;
  logic [XLEN-1:0]       lkp_ft_s, lkp_tgt_s, lkp_npc_s;
  branch_type_e          lkp_br_s;

  logic [HW-1:0]         upd_pc_h_s, upd_tgt_h_s;
  logic [FHW-1:0]        upd_pc_fh_s, upd_ft_fh_s;
  logic                  enc_fit_s, enc_ovf_s, enc_udf_s, enc_c0_s, enc_c1_s, enc_ok_s;
  tar_stat_e             enc_stat_s;

  logic [NWAYS-1:0]      upd_match_s, upd_free_s;
  logic                  upd_hit_s, upd_use_rr_s, upd_new_tgt_s;
  logic [WAYW-1:0]       upd_way_s, rr_next_s;
  logic [CNTR_W-1:0]     upd_old_cntr_s, upd_cntr_s;
  logic                  unused_s;

  assign unused_s = ^{lkp_pc[0], upd_pc[0], upd_fallthru[0], upd_target[0]};

  assign lkp_acc_s  = lkp_vld & lkp_rdy_r;
  assign upd_acc_s  = upd_vld & upd_rdy_r & ~flush;
  assign init_clr_s = (state_r == ST_INIT) & ~flush;
  assign upd_wr_s   = (state_r == ST_UPD) & ~flush & u_ok_r;

  // Next-state logic: sweep one set per cycle in INIT; flush always restarts the sweep.
  always_comb begin
    next_state_s     = state_r;
    sweep_idx_next_s = {IDXW{1'b0}};
    case (state_r)
      ST_INIT: begin
        sweep_idx_next_s = sweep_idx_r + IDX_ONE;
        if (sweep_idx_r == IDX_LAST) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (upd_vld) begin
          next_state_s = ST_UPD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_UPD:  next_state_s = ST_IDLE;
      default: next_state_s = ST_INIT;
    endcase
    if (flush) begin
      next_state_s     = ST_INIT;
      sweep_idx_next_s = {IDXW{1'b0}};
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State register plus ready flags derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      sweep_idx_r <= {IDXW{1'b0}};
      lkp_rdy_r   <= 1'b0;
      upd_rdy_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      sweep_idx_r <= sweep_idx_next_s;
      lkp_rdy_r   <= (next_state_s != ST_INIT);
      upd_rdy_r   <= (next_state_s == ST_IDLE);
    end
  end

  assign lkp_idx_s = lkp_pc[IDXW:1];
  assign lkp_tag_s = lkp_pc[IDXW+TAG_W:IDXW+1];
  assign lkp_h_s   = lkp_pc[XLEN-1:TARGET_W+1];
  assign lkp_fh_s  = lkp_pc[XLEN-1:FALLTHRU_W+1];

  // Tag match on the indexed set and decode of target / fall-through relative to lkp_pc.
  always_comb begin
    lkp_match_s = {NWAYS{1'b0}};
    for (int w = 0; w < NWAYS; w++) begin
      lkp_match_s[w] = vld_r[lkp_idx_s][w] & (tag_r[lkp_idx_s][w] == lkp_tag_s);
    end
    lkp_hit_s = |lkp_match_s;
    lkp_way_s = low_way(lkp_match_s);
    case (stat_r[lkp_idx_s][lkp_way_s])
      TAR_OVF: lkp_th_s = lkp_h_s + H_ONE;
      TAR_UDF: lkp_th_s = lkp_h_s - H_ONE;
      default: lkp_th_s = lkp_h_s;
    endcase
    lkp_tgt_s = {lkp_th_s, tgt_r[lkp_idx_s][lkp_way_s], 1'b0};
    if (lkp_hit_s) begin
      lkp_ft_s    = {lkp_fh_s + FHW'(carry_r[lkp_idx_s][lkp_way_s]),
                     ft_r[lkp_idx_s][lkp_way_s], 1'b0};
      lkp_taken_s = cntr_r[lkp_idx_s][lkp_way_s][CNTR_W-1];
      lkp_br_s    = br_r[lkp_idx_s][lkp_way_s];
    end else begin
      // A miss predicts the largest block: next aligned fall-through window.
      lkp_ft_s    = {lkp_fh_s + F_ONE, {FALLTHRU_W{1'b0}}, 1'b0};
      lkp_taken_s = 1'b0;
      lkp_br_s    = BR_NONE;
    end
    if (lkp_taken_s) begin
      lkp_npc_s = lkp_tgt_s;
    end else begin
      lkp_npc_s = lkp_ft_s;
    end
  end

  // Response register: valid for exactly one cycle per accepted lookup, data held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_r   <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_taken_r <= 1'b0;
      rsp_ft_r    <= {XLEN{1'b0}};
      rsp_npc_r   <= {XLEN{1'b0}};
      rsp_br_r    <= BR_NONE;
    end else begin
      rsp_vld_r <= lkp_acc_s;
      if (lkp_acc_s) begin
        rsp_hit_r   <= lkp_hit_s;
        rsp_taken_r <= lkp_taken_s;
        rsp_ft_r    <= lkp_ft_s;
        rsp_npc_r   <= lkp_npc_s;
        rsp_br_r    <= lkp_br_s;
      end
    end
  end

  assign upd_pc_h_s  = upd_pc[XLEN-1:TARGET_W+1];
  assign upd_tgt_h_s = upd_target[XLEN-1:TARGET_W+1];
  assign upd_pc_fh_s = upd_pc[XLEN-1:FALLTHRU_W+1];
  assign upd_ft_fh_s = upd_fallthru[XLEN-1:FALLTHRU_W+1];
  assign enc_fit_s   = (upd_tgt_h_s == upd_pc_h_s);
  assign enc_ovf_s   = (upd_tgt_h_s == (upd_pc_h_s + H_ONE));
  assign enc_udf_s   = (upd_tgt_h_s == (upd_pc_h_s - H_ONE));
  assign enc_c0_s    = (upd_ft_fh_s == upd_pc_fh_s);
  assign enc_c1_s    = (upd_ft_fh_s == (upd_pc_fh_s + F_ONE));
  assign enc_ok_s    = (enc_fit_s | enc_ovf_s | enc_udf_s) & (enc_c0_s | enc_c1_s);

  // Target compression status for the incoming update.
  always_comb begin
    if (enc_ovf_s) begin
      enc_stat_s = TAR_OVF;
    end else if (enc_udf_s) begin
      enc_stat_s = TAR_UDF;
    end else begin
      enc_stat_s = TAR_FIT;
    end
  end

  // Latch an accepted update; the drop pulse appears the cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_drop_r <= 1'b0;
      u_idx_r    <= {IDXW{1'b0}};
      u_tag_r    <= {TAG_W{1'b0}};
      u_tgt_r    <= {TARGET_W{1'b0}};
      u_stat_r   <= TAR_FIT;
      u_carry_r  <= 1'b0;
      u_ft_r     <= {FALLTHRU_W{1'b0}};
      u_taken_r  <= 1'b0;
      u_br_r     <= BR_NONE;
      u_ok_r     <= 1'b0;
    end else begin
      upd_drop_r <= upd_acc_s & ~enc_ok_s;
      if (upd_acc_s) begin
        u_idx_r   <= upd_pc[IDXW:1];
        u_tag_r   <= upd_pc[IDXW+TAG_W:IDXW+1];
        u_tgt_r   <= upd_target[TARGET_W:1];
        u_stat_r  <= enc_stat_s;
        u_carry_r <= enc_c1_s;
        u_ft_r    <= upd_fallthru[FALLTHRU_W:1];
        u_taken_r <= upd_taken;
        u_br_r    <= upd_brtype;
        u_ok_r    <= enc_ok_s;
      end
    end
  end

  // Way selection and counter update for the latched request.
  always_comb begin
    upd_match_s = {NWAYS{1'b0}};
    for (int w = 0; w < NWAYS; w++) begin
      upd_match_s[w] = vld_r[u_idx_r][w] & (tag_r[u_idx_r][w] == u_tag_r);
    end
    upd_hit_s    = |upd_match_s;
    upd_free_s   = ~vld_r[u_idx_r];
    upd_use_rr_s = 1'b0;
    if (upd_hit_s) begin
      upd_way_s = low_way(upd_match_s);
    end else if (|upd_free_s) begin
      upd_way_s = low_way(upd_free_s);
    end else begin
      upd_way_s    = rr_r[u_idx_r];
      upd_use_rr_s = 1'b1;
    end
    upd_old_cntr_s = cntr_r[u_idx_r][upd_way_s];
    if (upd_hit_s) begin
      if (u_taken_r) begin
        upd_cntr_s = (upd_old_cntr_s == CNTR_MAX) ? CNTR_MAX : upd_old_cntr_s + CNTR_ONE;
      end else begin
        upd_cntr_s = (upd_old_cntr_s == CNTR_ZERO) ? CNTR_ZERO : upd_old_cntr_s - CNTR_ONE;
      end
    end else begin
      upd_cntr_s = u_taken_r ? CNTR_WEAKT : CNTR_WEAKN;
    end
    upd_new_tgt_s = ~upd_hit_s | u_taken_r;
    if (NWAYS == 1) begin
      rr_next_s = {WAYW{1'b0}};
    end else begin
      rr_next_s = rr_r[u_idx_r] + WAY_ONE;
    end
  end

  // Valid bits, carry bits and replacement pointers: sweep clear or update write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r   <= '{default: {NWAYS{1'b0}}};
      carry_r <= '{default: {NWAYS{1'b0}}};
      rr_r    <= '{default: {WAYW{1'b0}}};
    end else if (init_clr_s) begin
      vld_r[sweep_idx_r] <= {NWAYS{1'b0}};
    end else if (upd_wr_s) begin
      vld_r[u_idx_r][upd_way_s]   <= 1'b1;
      carry_r[u_idx_r][upd_way_s] <= u_carry_r;
      if (upd_use_rr_s) begin
        rr_r[u_idx_r] <= rr_next_s;
      end
    end
  end

  // Payload write for the selected way; tag only changes on allocation.
  always_ff @(posedge clk) begin
    if (upd_wr_s) begin
      cntr_r[u_idx_r][upd_way_s] <= upd_cntr_s;
      ft_r[u_idx_r][upd_way_s]   <= u_ft_r;
      if (upd_new_tgt_s) begin
        tgt_r[u_idx_r][upd_way_s]  <= u_tgt_r;
        stat_r[u_idx_r][upd_way_s] <= u_stat_r;
        br_r[u_idx_r][upd_way_s]   <= u_br_r;
      end
      if (!upd_hit_s) begin
        tag_r[u_idx_r][upd_way_s] <= u_tag_r;
      end
    end
  end

  assign lkp_rdy      = lkp_rdy_r;
  assign upd_rdy      = upd_rdy_r;
  assign upd_drop     = upd_drop_r;
  assign rsp_vld      = rsp_vld_r;
  assign rsp_hit      = rsp_hit_r;
  assign rsp_taken    = rsp_taken_r;
  assign rsp_fallthru = rsp_ft_r;
  assign rsp_npc      = rsp_npc_r;
  assign rsp_brtype   = rsp_br_r;

endmodule
